result_display: RTL

- Output-side counterpart of the switch input stage in the multiplier design: the switches supply the operands, and this block shows the product on the board's seven-segment displays.
- Accepts a signed 18-bit product (9-bit x 9-bit) from the multiplier core through a start/ready handshake.
- Converts the magnitude to BCD with an iterative shift-add-3 (double-dabble) FSM, then drives five digit displays plus one sign display.
- Applies leading-zero blanking to the digit displays.

---
 rtl/pkg_mult.sv | 22 ++
 rtl/seg7_decoder.sv | 30 +++
 rtl/result_display.sv | 112 +++++++++++
 3 files changed

// File: rtl/pkg_mult.sv
// Shared types and constants for the multiplier datapath and its
// seven-segment result display.
package pkg_mult;

    localparam int NDIG        = 5;
    localparam int CONV_CYCLES = 17;

    typedef logic signed [17:0] product_t;
    typedef logic [3:0]         bcd_t;
    typedef logic [6:0]         seg_t;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        UPDATE
    } disp_state_e;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_MINUS = 7'h3F;
    localparam seg_t SEG_ZERO  = 7'h40;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Non-decimal nibbles and blanked digits both show nothing.
module seg7_decoder
    import pkg_mult::*;
(
    input  bcd_t digit,
    input  logic blank,
    output seg_t seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            unique case (digit)
                4'd0:    seg = 7'h40;
                4'd1:    seg = 7'h79;
                4'd2:    seg = 7'h24;
                4'd3:    seg = 7'h30;
                4'd4:    seg = 7'h19;
                4'd5:    seg = 7'h12;
                4'd6:    seg = 7'h02;
                4'd7:    seg = 7'h78;
                4'd8:    seg = 7'h00;
                4'd9:    seg = 7'h10;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_display.sv
// Signed product to five decimal digits plus sign on seven-segment
// displays, using an iterative double-dabble conversion.
module result_display
    import pkg_mult::*;
#(
    parameter int DW = 18
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [DW-1:0] i_result,
    output logic          o_ready,
    output logic          o_done,
    output seg_t          o_hex0,
    output seg_t          o_hex1,
    output seg_t          o_hex2,
    output seg_t          o_hex3,
    output seg_t          o_hex4,
    output seg_t          o_hex5
);

    localparam int BW = 4 * NDIG;

    disp_state_e   state_r;
    logic          neg_r;
    logic [DW-1:0] mag_r;
    logic [BW-1:0] bcd_r;
    logic [BW-1:0] bcd_adj;
    logic [4:0]    cnt_r;
    logic [NDIG-1:0] blank;
    seg_t          seg_w [NDIG];

    always_comb begin
        bcd_adj = bcd_r;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
        end
    end

    // A digit blanks only if it and every more significant digit are zero.
    always_comb begin
        blank = '0;
        blank[NDIG-1] = (bcd_r[4*(NDIG-1) +: 4] == 4'd0);
        for (int i = NDIG - 2; i >= 1; i--)
            blank[i] = blank[i+1] && (bcd_r[4*i +: 4] == 4'd0);
        blank[0] = 1'b0;
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dec
        seg7_decoder u_dec (
            .digit (bcd_r[4*g +: 4]),
            .blank (blank[g]),
            .seg   (seg_w[g])
        );
    end

    // The magnitude's top bit is always zero, so the shift feeds from DW-2.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r <= IDLE;
            neg_r   <= 1'b0;
            mag_r   <= '0;
            bcd_r   <= '0;
            cnt_r   <= '0;
            o_ready <= 1'b1;
            o_done  <= 1'b0;
            o_hex0  <= SEG_ZERO;
            o_hex1  <= SEG_BLANK;
            o_hex2  <= SEG_BLANK;
            o_hex3  <= SEG_BLANK;
            o_hex4  <= SEG_BLANK;
            o_hex5  <= SEG_BLANK;
        end else begin
            o_done <= 1'b0;
            unique case (state_r)
                IDLE: begin
                    if (i_start) begin
                        neg_r   <= i_result[DW-1];
                        mag_r   <= i_result[DW-1] ? DW'(-i_result)
                                                  : i_result;
                        bcd_r   <= '0;
                        cnt_r   <= 5'(CONV_CYCLES);
                        o_ready <= 1'b0;
                        state_r <= CONV;
                    end
                end
                CONV: begin
                    bcd_r <= {bcd_adj[BW-2:0], mag_r[DW-2]};
                    mag_r <= mag_r << 1;
                    cnt_r <= cnt_r - 5'd1;
                    if (cnt_r == 5'd1)
                        state_r <= UPDATE;
                end
                UPDATE: begin
                    o_hex0  <= seg_w[0];
                    o_hex1  <= seg_w[1];
                    o_hex2  <= seg_w[2];
                    o_hex3  <= seg_w[3];
                    o_hex4  <= seg_w[4];
                    o_hex5  <= (neg_r && bcd_r != '0) ? SEG_MINUS
                                                      : SEG_BLANK;
                    o_done  <= 1'b1;
                    o_ready <= 1'b1;
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
